// File: rtl/multicycle_pc_control_pkg.sv
// Shared constants for the multicycle MIPS-subset control path: opcodes,
// datapath select codes and the control FSM state encoding.
package multicycle_pc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PCS_SEQ = 2'd0;
  localparam logic [1:0] PCS_BR  = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;
  localparam logic [1:0] PCS_VEC = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_e;

endpackage

// File: rtl/multicycle_pc_control_pc_write_logic.sv
// Final PC load enable: unconditional write or a satisfied branch condition.
module pc_write_logic (
  input  logic PCWrite,
  input  logic BranchEq,
  input  logic BranchNe,
  input  logic zero,
  output logic PCWriteEn
);

  assign PCWriteEn = PCWrite | (BranchEq & zero) | (BranchNe & ~zero);

endmodule

// File: rtl/multicycle_pc_control.sv
// Moore control FSM for the multicycle MIPS-subset CPU: sequences each
// instruction and drives the next-PC mux select, PC enable and datapath strobes.
module multicycle_pc_control
  import multicycle_pc_control_pkg::*;
#(
  parameter logic [1:0] VEC_SEL = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] PCSource,
  output logic       PCWriteEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   pc_write, br_eq, br_ne, mem_read, ir_write, pc_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      // Only lw/sw reach here; anything else just restarts the fetch.
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCSource = PCS_SEQ;
    pc_write = 1'b0;
    br_eq    = 1'b0;
    br_ne    = 1'b0;
    IorD     = 1'b0;
    mem_read = 1'b0;
    MemWrite = 1'b0;
    ir_write = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    ALUOp    = ALU_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        ALUSrcB  = SRCB_4;
        pc_write = 1'b1;
      end
      S_DECODE: ALUSrcB = SRCB_SHIMM;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCS_BR;
        br_eq    = (op == OP_BEQ);
        br_ne    = (op == OP_BNE);
      end
      S_JUMP: begin
        PCSource = PCS_JMP;
        pc_write = 1'b1;
      end
      S_ILLEGAL: begin
        PCSource = VEC_SEL;
        pc_write = 1'b1;
        illegal  = 1'b1;
      end
      default: ;
    endcase
  end

  pc_write_logic u_pc_write_logic (
    .PCWrite   (pc_write),
    .BranchEq  (br_eq),
    .BranchNe  (br_ne),
    .zero      (zero),
    .PCWriteEn (pc_we)
  );

  // State is already FETCH during reset; mask the strobes with side effects.
  assign PCWriteEn = pc_we & ~reset;
  assign MemRead   = mem_read & ~reset;
  assign IRWrite   = ir_write & ~reset;

endmodule

// File: tb/tb_multicycle_pc_control.sv
// Bench for multicycle_pc_control: a per-instruction cycle table model checked
// every cycle, plus directed literal checks on key cycles of each instruction.
module tb_multicycle_pc_control;
  import multicycle_pc_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       PCWriteEn, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic run_chk = 1'b0;
  logic [15:0] snap [0:5];
  logic [15:0] dut_w;

  multicycle_pc_control #(.VEC_SEL(2'd3)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .PCSource(PCSource), .PCWriteEn(PCWriteEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // [15:14]PCSource [13]PCWriteEn [12]IorD [11]MemRead [10]MemWrite [9]IRWrite
  // [8]MemtoReg [7]RegDst [6]RegWrite [5]ALUSrcA [4:3]ALUSrcB [2:1]ALUOp [0]illegal
  assign dut_w = {PCSource, PCWriteEn, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal};

  function automatic logic [15:0] mk(input logic [1:0] pcs, input logic pcwe,
      input logic iord, input logic mr, input logic mw, input logic irw,
      input logic m2r, input logic rd, input logic rw, input logic sa,
      input logic [1:0] sb, input logic [1:0] aop, input logic ill);
    return {pcs, pcwe, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ill};
  endfunction

  // Instruction length in cycles, FETCH to FETCH.
  function automatic int ilen(input logic [5:0] o);
    case (o)
      OP_LW:                   return 5;
      OP_SW, OP_RTYPE, OP_ADDI: return 4;
      default:                 return 3;
    endcase
  endfunction

  // What the controls must be on cycle k (0 = fetch) of an instruction.
  function automatic logic [15:0] exp_word(input logic [5:0] o, input int k, input logic z);
    logic [15:0] addr;
    addr = mk(2'd0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,0);
    if (k == 0) return mk(2'd0,1,0,1,0,1,0,0,0,0,2'd1,2'd0,0);
    if (k == 1) return mk(2'd0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,0);
    case (o)
      OP_LW:    return (k == 2) ? addr :
                       (k == 3) ? mk(2'd0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,0)
                                : mk(2'd0,0,0,0,0,0,1,0,1,0,2'd0,2'd0,0);
      OP_SW:    return (k == 2) ? addr : mk(2'd0,0,1,0,1,0,0,0,0,0,2'd0,2'd0,0);
      OP_RTYPE: return (k == 2) ? mk(2'd0,0,0,0,0,0,0,0,0,1,2'd0,2'd2,0)
                                : mk(2'd0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,0);
      OP_ADDI:  return (k == 2) ? addr : mk(2'd0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,0);
      OP_BEQ:   return mk(2'd1,z,0,0,0,0,0,0,0,1,2'd0,2'd1,0);
      OP_BNE:   return mk(2'd1,~z,0,0,0,0,0,0,0,1,2'd0,2'd1,0);
      OP_J:     return mk(2'd2,1,0,0,0,0,0,0,0,0,2'd0,2'd0,0);
      default:  return mk(2'd3,1,0,0,0,0,0,0,0,0,2'd0,2'd0,1);
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= (cyc + 1 >= ilen(op)) ? 0 : cyc + 1;
  end

  always @(negedge clk) begin
    if (run_chk)
      chk("cycle", dut_w,
          reset ? mk(2'd0,0,0,0,0,0,0,0,0,0,2'd1,2'd0,0) : exp_word(op, cyc, zero));
  end

  // Issue one instruction from FETCH; snap[k] holds the controls of cycle k,
  // and snap[len] is the following FETCH.
  task automatic run(input logic [5:0] o, input logic z);
    int n;
    op = o;
    zero = z;
    n = ilen(o);
    snap[0] = dut_w;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #2;
      snap[k] = dut_w;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    op    = 6'h00;
    zero  = 1'b0;
    @(posedge clk); #2;
    run_chk = 1'b1;
    chk("rst_pcwe",   16'(PCWriteEn), 16'd0);
    chk("rst_memrd",  16'(MemRead),   16'd0);
    chk("rst_alusrcb", 16'(ALUSrcB),  16'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rel_fetch", 16'({PCSource, PCWriteEn, MemRead}), 16'b0011);

    run(OP_LW, 1'($urandom));
    chk("lw_memrd", 16'({snap[3][12], snap[3][11]}), 16'b11);
    chk("lw_memwb", 16'({snap[4][6], snap[4][8], snap[4][7]}), 16'b110);
    chk("lw_refetch", 16'(snap[5][9]), 16'd1);

    run(OP_BEQ, 1'b1);
    chk("beq_t", 16'({snap[2][15:14], snap[2][13]}), 16'b011);
    chk("beq_t_next", 16'(snap[3][9]), 16'd1);
    run(OP_BEQ, 1'b0);
    chk("beq_nt", 16'({snap[2][15:14], snap[2][13]}), 16'b010);
    run(OP_BNE, 1'b0);
    chk("bne_t", 16'({snap[2][15:14], snap[2][13]}), 16'b011);
    run(OP_BNE, 1'b1);
    chk("bne_nt", 16'(snap[2][13]), 16'd0);

    run(OP_J, 1'($urandom));
    chk("j_pc", 16'({snap[2][15:14], snap[2][13]}), 16'b101);
    run(OP_RTYPE, 1'($urandom));
    chk("r_exec", 16'(snap[2][2:1]), 16'd2);
    chk("r_wb", 16'({snap[3][7], snap[3][6]}), 16'b11);
    run(OP_ADDI, 1'($urandom));
    chk("addi_wb", 16'({snap[3][7], snap[3][6], snap[3][8]}), 16'b010);
    run(OP_SW, 1'($urandom));
    chk("sw_wr", 16'({snap[3][12], snap[3][10]}), 16'b11);

    run(6'h3F, 1'($urandom));
    chk("ill_vec", 16'({snap[2][15:14], snap[2][13], snap[2][0]}), 16'b1111);
    chk("ill_once", 16'({snap[1][0], snap[3][0]}), 16'b00);
    chk("ill_refetch", 16'(snap[3][9]), 16'd1);

    // Reset lands in the middle of a store's write cycle.
    op = OP_SW;
    repeat (3) begin @(posedge clk); #2; end
    chk("sw_pre_rst", 16'(MemWrite), 16'd1);
    reset = 1'b1;
    #1;
    chk("rst_memwr", 16'({MemWrite, MemRead, PCWriteEn, IRWrite}), 16'b0000);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rel2_fetch", 16'({PCSource, PCWriteEn, MemRead}), 16'b0011);

    run(OP_LW, 1'b0);
    run(OP_BNE, 1'b0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
